// File: rtl/lspc2_pkg.sv
// Shared constants and types for the LSPC2 raster timing generator.
package lspc2_pkg;

  localparam logic [8:0] V_START_NTSC = 9'h0F8;
  localparam logic [8:0] V_START_PAL  = 9'h0C8;
  localparam logic [8:0] V_LAST       = 9'h1FF;
  localparam logic [8:0] VSYNC_FIRST  = 9'h0F8;
  localparam logic [8:0] VSYNC_LAST   = 9'h0FF;

  typedef enum logic {
    VMODE_NTSC = 1'b0,
    VMODE_PAL  = 1'b1
  } vmode_t;

  function automatic logic [8:0] v_start_of(input vmode_t mode);
    return (mode == VMODE_PAL) ? V_START_PAL : V_START_NTSC;
  endfunction

endpackage

// File: rtl/lspc2_vdecode.sv
// Registered V-range decode for VSYNC_n, VBLANK and VBL_IRQ, updated on the edge V is written.
// One CLK from i_v_adv; no flow control, decodes hold while V holds.
module lspc2_vdecode
  import lspc2_pkg::*;
#(
  parameter logic [8:0] V_ACT_START = 9'h110,
  parameter logic [8:0] V_ACT_END   = 9'h1F0
) (
  input  logic       CLK,
  input  logic       nRESETP,
  input  logic       i_v_adv,
  input  logic [8:0] i_v_nxt,
  output logic       o_vsync_n,
  output logic       o_vblank,
  output logic       o_vbl_irq
);

  logic r_vsync_n;
  logic r_vblank;
  logic r_vbl_irq;

  always_ff @(posedge CLK) begin
    if (!nRESETP) begin
      r_vsync_n <= 1'b0;
      r_vblank  <= 1'b1;
      r_vbl_irq <= 1'b0;
    end else begin
      r_vbl_irq <= i_v_adv && (i_v_nxt == V_ACT_END);
      if (i_v_adv) begin
        r_vsync_n <= !((i_v_nxt >= VSYNC_FIRST) && (i_v_nxt <= VSYNC_LAST));
        r_vblank  <= (i_v_nxt < V_ACT_START) || (i_v_nxt >= V_ACT_END);
      end
    end
  end

  assign o_vsync_n = r_vsync_n;
  assign o_vblank  = r_vblank;
  assign o_vbl_irq = r_vbl_irq;

endmodule

// File: rtl/lspc2_video_timing.sv
// LSPC2 raster timing: H/V counters, syncs, blanks, line/frame strobes and VBLANK IRQ.
// Registered outputs one CLK after an enabled edge; no backpressure, state holds while the enable is low.
module lspc2_video_timing
  import lspc2_pkg::*;
#(
  parameter int         H_TOTAL     = 384,
  parameter int         HSYNC_W     = 32,
  parameter int         H_ACT_START = 30,
  parameter int         H_ACT_W     = 320,
  parameter logic [8:0] V_ACT_START = 9'h110,
  parameter logic [8:0] V_ACT_END   = 9'h1F0
) (
  input  logic       CLK,
  input  logic       nRESETP,
  input  logic       LSPC_EN_6M_P,
  input  logic       VMODE,
  output logic [8:0] H_CNT,
  output logic [8:0] V_CNT,
  output logic       HSYNC_n,
  output logic       VSYNC_n,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic       VBL_IRQ,
  output logic [7:0] FRAME_CNT
);

  localparam logic [8:0] H_LAST      = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_SYNC_END  = 9'(HSYNC_W);
  localparam logic [8:0] H_ACT_FIRST = 9'(H_ACT_START);
  localparam logic [8:0] H_ACT_END   = 9'(H_ACT_START + H_ACT_W);

  logic [8:0] r_h;
  logic [8:0] r_v;
  vmode_t     r_mode;
  logic [7:0] r_frame_cnt;
  logic       r_hsync_n;
  logic       r_hblank;
  logic       r_line_start;
  logic       r_frame_start;

  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_v_adv;
  logic [8:0] w_h_nxt;
  logic [8:0] w_v_nxt;

  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_v_adv  = LSPC_EN_6M_P && w_h_wrap;
  assign w_h_nxt  = w_h_wrap ? 9'd0 : r_h + 9'd1;

  // The mode sampled on the wrap edge picks the start line loaded on that same edge.
  always_comb begin
    w_v_nxt = r_v;
    if (w_v_adv) begin
      w_v_nxt = w_v_wrap ? v_start_of(vmode_t'(VMODE)) : r_v + 9'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESETP) begin
      r_h           <= 9'd0;
      r_v           <= V_START_NTSC;
      r_mode        <= VMODE_NTSC;
      r_frame_cnt   <= 8'd0;
      r_hsync_n     <= 1'b0;
      r_hblank      <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (LSPC_EN_6M_P) begin
        r_h          <= w_h_nxt;
        r_hsync_n    <= !(w_h_nxt < H_SYNC_END);
        r_hblank     <= (w_h_nxt < H_ACT_FIRST) || (w_h_nxt >= H_ACT_END);
        r_line_start <= w_h_wrap;
        if (w_h_wrap) begin
          r_v <= w_v_nxt;
          if (w_v_wrap) begin
            r_mode        <= vmode_t'(VMODE);
            r_frame_start <= 1'b1;
            r_frame_cnt   <= r_frame_cnt + 8'd1;
          end
        end
      end
    end
  end

  lspc2_vdecode #(
    .V_ACT_START (V_ACT_START),
    .V_ACT_END   (V_ACT_END)
  ) u_vdecode (
    .CLK       (CLK),
    .nRESETP   (nRESETP),
    .i_v_adv   (w_v_adv),
    .i_v_nxt   (w_v_nxt),
    .o_vsync_n (VSYNC_n),
    .o_vblank  (VBLANK),
    .o_vbl_irq (VBL_IRQ)
  );

  assign H_CNT       = r_h;
  assign V_CNT       = r_v;
  assign HSYNC_n     = r_hsync_n;
  assign HBLANK      = r_hblank;
  assign LINE_START  = r_line_start;
  assign FRAME_START = r_frame_start;
  assign FRAME_CNT   = r_frame_cnt;

endmodule

// File: tb/tb_lspc2_video_timing.sv
// Bench for lspc2_video_timing: a short-line instance against a frame-position model,
// plus a one-pixel-line instance that runs 256 frames to reach the frame counter wrap.
module tb_lspc2_video_timing;

  localparam int HT  = 16;
  localparam int HSW = 4;
  localparam int HAS = 3;
  localparam int HAW = 10;
  localparam int VAS = 'h110;
  localparam int VAE = 'h1F0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, vmode;
  logic [8:0] h_cnt, v_cnt;
  logic       hsync_n, vsync_n, hblank, vblank, line_start, frame_start, vbl_irq;
  logic [7:0] frame_cnt;

  logic       f_rst_n, f_en;
  logic [8:0] f_h_cnt, f_v_cnt;
  logic       f_hsync_n, f_vsync_n, f_hblank, f_vblank, f_line_start, f_frame_start, f_vbl_irq;
  logic [7:0] f_frame_cnt;

  lspc2_video_timing #(
    .H_TOTAL(HT), .HSYNC_W(HSW), .H_ACT_START(HAS), .H_ACT_W(HAW),
    .V_ACT_START(9'h110), .V_ACT_END(9'h1F0)
  ) u_dut (
    .CLK(clk), .nRESETP(rst_n), .LSPC_EN_6M_P(en), .VMODE(vmode),
    .H_CNT(h_cnt), .V_CNT(v_cnt), .HSYNC_n(hsync_n), .VSYNC_n(vsync_n),
    .HBLANK(hblank), .VBLANK(vblank), .LINE_START(line_start),
    .FRAME_START(frame_start), .VBL_IRQ(vbl_irq), .FRAME_CNT(frame_cnt)
  );

  lspc2_video_timing #(
    .H_TOTAL(1), .HSYNC_W(1), .H_ACT_START(1), .H_ACT_W(1),
    .V_ACT_START(9'h110), .V_ACT_END(9'h1F0)
  ) u_fc (
    .CLK(clk), .nRESETP(f_rst_n), .LSPC_EN_6M_P(f_en), .VMODE(1'b0),
    .H_CNT(f_h_cnt), .V_CNT(f_v_cnt), .HSYNC_n(f_hsync_n), .VSYNC_n(f_vsync_n),
    .HBLANK(f_hblank), .VBLANK(f_vblank), .LINE_START(f_line_start),
    .FRAME_START(f_frame_start), .VBL_IRQ(f_vbl_irq), .FRAME_CNT(f_frame_cnt)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: position within the frame in enables, latched mode, frame count.
  int m_k, m_mode, m_fc;
  bit m_pul;
  int n_en, last_fs, fs_period, fs_cnt, irq_cnt, vs_lines, ls_cnt;

  function automatic int vs(input int mode);
    return (mode != 0) ? 'hC8 : 'hF8;
  endfunction
  function automatic int flen(input int mode);
    return (512 - vs(mode)) * HT;
  endfunction
  function automatic int mh();
    return m_k % HT;
  endfunction
  function automatic int mv();
    return vs(m_mode) + m_k / HT;
  endfunction

  task automatic cyc(input bit r, input bit e);
    int h, v;
    rst_n = r;
    en    = e;
    @(posedge clk);
    if (!r) begin
      m_k = 0; m_mode = 0; m_fc = 0; m_pul = 0;
      n_en = 0; last_fs = 0; fs_period = 0; fs_cnt = 0;
      irq_cnt = 0; vs_lines = 0; ls_cnt = 0;
    end else if (e) begin
      m_k++;
      n_en++;
      if (m_k == flen(m_mode)) begin
        m_k = 0;
        m_mode = int'(vmode);
        m_fc = (m_fc + 1) % 256;
      end
      m_pul = 1'b1;
    end else begin
      m_pul = 1'b0;
    end
    #1;
    h = mh();
    v = mv();
    chk("h_cnt", h_cnt, h);
    chk("v_cnt", v_cnt, v);
    chk("hsync_n", hsync_n, (h < HSW) ? 0 : 1);
    chk("hblank", hblank, (h < HAS || h >= HAS + HAW) ? 1 : 0);
    chk("vsync_n", vsync_n, (v >= 'hF8 && v <= 'hFF) ? 0 : 1);
    chk("vblank", vblank, (v < VAS || v >= VAE) ? 1 : 0);
    chk("line_start", line_start, (m_pul && h == 0) ? 1 : 0);
    chk("frame_start", frame_start, (m_pul && m_k == 0) ? 1 : 0);
    chk("vbl_irq", vbl_irq, (m_pul && h == 0 && v == VAE) ? 1 : 0);
    chk("frame_cnt", frame_cnt, m_fc);
    if (frame_start) begin
      fs_period = n_en - last_fs;
      last_fs = n_en;
      fs_cnt++;
    end
    if (vbl_irq) irq_cnt++;
    if (line_start) begin
      ls_cnt++;
      if (!vsync_n) vs_lines++;
    end
  endtask

  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1);
  endtask

  typedef struct {
    bit rst_n;
    bit en;
    int h;
    int v;
    bit hs_n;
    bit hbl;
    bit ls;
  } vec_t;
  vec_t tbl[7];

  bit fc_done = 1'b0;
  int fc_seen, fc_last, fc_t;
  logic [7:0] fc_prev;

  initial begin
    f_rst_n = 1'b0;
    f_en    = 1'b1;
    fc_seen = 0; fc_last = 0; fc_t = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("fc_reset", f_frame_cnt, 0);
    f_rst_n = 1'b1;
    fc_prev = f_frame_cnt;
    while (fc_seen < 256 && fc_t < 256 * 264 + 600) begin
      @(posedge clk);
      #1;
      fc_t++;
      if (f_frame_start) begin
        fc_seen++;
        chk("fc_value", f_frame_cnt, fc_seen % 256);
        chk("fc_period", fc_t - fc_last, 264);
        fc_last = fc_t;
      end else if (f_frame_cnt != fc_prev) begin
        chk("fc_step_without_frame_start", f_frame_cnt, fc_prev);
      end
      fc_prev = f_frame_cnt;
    end
    chk("fc_frames", fc_seen, 256);
    chk("fc_wrap", f_frame_cnt, 0);
    fc_done = 1'b1;
  end

  initial begin
    int steps;
    rst_n = 1'b0;
    en    = 1'b0;
    vmode = 1'b0;

    tbl[0] = '{1'b0, 1'b1, 0, 'hF8, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 0, 'hF8, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1, 'hF8, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 2, 'hF8, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 2, 'hF8, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 3, 'hF8, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 4, 'hF8, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      rst_n = tbl[i].rst_n;
      en    = tbl[i].en;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_h", i), h_cnt, tbl[i].h);
      chk($sformatf("vec%0d_v", i), v_cnt, tbl[i].v);
      chk($sformatf("vec%0d_hsync_n", i), hsync_n, tbl[i].hs_n);
      chk($sformatf("vec%0d_hblank", i), hblank, tbl[i].hbl);
      chk($sformatf("vec%0d_line_start", i), line_start, tbl[i].ls);
    end

    // One line with enables spaced 4 CLK apart.
    cyc(1'b0, 1'b1);
    for (int i = 0; i < HT; i++) begin
      cyc(1'b1, 1'b1);
      repeat (3) cyc(1'b1, 1'b0);
    end
    chk("line_wrap_h", h_cnt, 0);
    chk("line_wrap_v", v_cnt, 'hF9);
    chk("line_start_count", ls_cnt, 1);

    // Rest of the first NTSC frame.
    run_en(264 * HT - HT - 1);
    chk("ntsc_last_line", v_cnt, 'h1FF);
    cyc(1'b1, 1'b1);
    chk("ntsc_wrap_v", v_cnt, 'hF8);
    chk("ntsc_frame_period", fs_period, 264 * HT);
    chk("ntsc_frame_starts", fs_cnt, 1);
    chk("ntsc_irq_count", irq_cnt, 1);
    chk("ntsc_vsync_lines", vs_lines, 8);

    // PAL requested mid-frame: this frame keeps NTSC length.
    run_en(('h150 - 'hF8) * HT);
    chk("pal_req_line", v_cnt, 'h150);
    vmode = 1'b1;
    irq_cnt = 0;
    run_en((264 - ('h150 - 'hF8)) * HT);
    chk("pal_switch_period", fs_period, 264 * HT);
    chk("pal_switch_v", v_cnt, 'hC8);
    chk("pal_switch_irq", irq_cnt, 1);
    run_en(312 * HT);
    chk("pal_frame_period", fs_period, 312 * HT);
    chk("pal_frame_v", v_cnt, 'hC8);

    // Random enable gaps and mode changes, crossing one frame wrap.
    for (int i = 0; i < 5200; i++) begin
      vmode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
    end

    // Reset mid-frame with the enable high.
    vmode = 1'b0;
    steps = 0;
    while (!(mv() == 'h180 && mh() == 9) && steps < 20000) begin
      cyc(1'b1, 1'b1);
      steps++;
    end
    chk("reach_reset_point", (mv() == 'h180 && mh() == 9) ? 1 : 0, 1);
    vmode = 1'($urandom_range(0, 1));
    cyc(1'b0, 1'b1);
    chk("rst_h", h_cnt, 0);
    chk("rst_v", v_cnt, 'hF8);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_hblank", hblank, 1);
    chk("rst_vblank", vblank, 1);
    chk("rst_pulses", {line_start, frame_start, vbl_irq}, 0);
    vmode = 1'b0;
    cyc(1'b1, 1'b1);
    chk("post_rst_h", h_cnt, 1);

    for (int t = 0; t < 100000 && !fc_done; t++) @(posedge clk);
    chk("fc_done", fc_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
